// File: rtl/conv_seq_mac_engine.sv
// Sequential NxN convolution: one multiply-accumulate per clock over the top-left window of
// snapshotted MAX_N x MAX_N operands, with the final sum saturated to a signed OUT_W result.
module conv_seq_mac_engine #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 5,
  parameter int OUT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [$clog2(MAX_N+1)-1:0]      size_n,
  input  logic                            pixel_signed,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   matrix_a,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   matrix_b,
  output logic                            busy,
  output logic                            done,
  output logic [OUT_W-1:0]                result,
  output logic                            sat,
  output logic                            err
);

  localparam int ACC_W  = 2*DATA_W + 1 + $clog2(MAX_N*MAX_N);
  localparam int SZ_W   = $clog2(MAX_N+1);
  localparam int CNT_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int IDX_W  = (MAX_N > 1) ? $clog2(MAX_N*MAX_N) : 1;
  localparam int PROD_W = 2*DATA_W + 1;
  localparam int MAT_W  = MAX_N*MAX_N*DATA_W;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**(OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;
  localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [OUT_W-1:0]         result_q, result_d;
  logic                     sat_q, sat_d;
  logic                     err_q, err_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         row_q, row_d;
  logic [CNT_W-1:0]         col_q, col_d;
  logic [CNT_W-1:0]         nm1_q, nm1_d;
  logic                     sgn_q, sgn_d;
  logic [MAT_W-1:0]         snap_a_q, snap_a_d;
  logic [MAT_W-1:0]         snap_b_q, snap_b_d;

  logic                     size_ok;
  logic [IDX_W-1:0]         idx;
  logic [DATA_W-1:0]        pix;
  logic signed [DATA_W:0]   pix_ext;
  logic signed [DATA_W-1:0] ker;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     clip_hi, clip_lo;

  assign size_ok = (size_n != '0) && (size_n <= SZ_W'(MAX_N));

  // Datapath reads only from the snapshot, so input changes mid-run cannot leak in.
  always_comb begin
    idx     = IDX_W'(row_q) * IDX_W'(MAX_N) + IDX_W'(col_q);
    pix     = snap_a_q[idx*DATA_W +: DATA_W];
    ker     = $signed(snap_b_q[idx*DATA_W +: DATA_W]);
    pix_ext = sgn_q ? $signed({pix[DATA_W-1], pix}) : $signed({1'b0, pix});
    prod    = PROD_W'(pix_ext) * PROD_W'(ker);
    acc_sum = acc_q + ACC_W'(prod);
    clip_hi = acc_sum > SAT_HI;
    clip_lo = acc_sum < SAT_LO;
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    sat_d    = sat_q;
    err_d    = err_q;
    acc_d    = acc_q;
    row_d    = row_q;
    col_d    = col_q;
    nm1_d    = nm1_q;
    sgn_d    = sgn_q;
    snap_a_d = snap_a_q;
    snap_b_d = snap_b_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          result_d = '0;
          sat_d    = 1'b0;
          if (size_ok) begin
            snap_a_d = matrix_a;
            snap_b_d = matrix_b;
            nm1_d    = CNT_W'(size_n - 1'b1);
            sgn_d    = pixel_signed;
            acc_d    = '0;
            row_d    = '0;
            col_d    = '0;
            busy_d   = 1'b1;
            err_d    = 1'b0;
            state_d  = RUN;
          end else begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        acc_d = acc_sum;
        if (col_q == nm1_q) begin
          col_d = '0;
          if (row_q == nm1_q) begin
            // Last MAC: saturate the updated sum directly so done carries a valid result.
            state_d  = DONE;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            err_d    = 1'b0;
            sat_d    = clip_hi | clip_lo;
            result_d = clip_hi ? OUT_MAX : (clip_lo ? OUT_MIN : acc_sum[OUT_W-1:0]);
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      nm1_q    <= '0;
      sgn_q    <= 1'b0;
      snap_a_q <= '0;
      snap_b_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      row_q    <= row_d;
      col_q    <= col_d;
      nm1_q    <= nm1_d;
      sgn_q    <= sgn_d;
      snap_a_q <= snap_a_d;
      snap_b_q <= snap_b_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign sat    = sat_q;
  assign err    = err_q;

endmodule

// File: tb/tb_conv_seq_mac_engine.sv
// Self-checking bench for conv_seq_mac_engine: directed cases plus randomized runs against an
// arithmetic reference model of the windowed multiply-accumulate with saturation.
module tb_conv_seq_mac_engine;

  localparam int DW  = 8;
  localparam int MN  = 5;
  localparam int OW  = 16;
  localparam int AW  = MN*MN*DW;
  localparam int SZW = $clog2(MN+1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [SZW-1:0] size_n = '0;
  logic           pixel_signed = 1'b0;
  logic [AW-1:0]  matrix_a = '0;
  logic [AW-1:0]  matrix_b = '0;
  logic           busy, done, sat, err;
  logic [OW-1:0]  result;

  int checks = 0;
  int errors = 0;

  conv_seq_mac_engine #(.DATA_W(DW), .MAX_N(MN), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size_n(size_n), .pixel_signed(pixel_signed),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .busy(busy), .done(done), .result(result),
    .sat(sat), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [AW-1:0] rand_mat();
    logic [AW-1:0] m;
    m = '0;
    for (int i = 0; i < MN*MN; i++) m[i*DW +: DW] = DW'($urandom);
    return m;
  endfunction

  // Reference: plain integer sum over the NxN window, then clip to the signed output range.
  function automatic void model(input int n, input bit ps, input logic [AW-1:0] a,
                                input logic [AW-1:0] b, output int res_o, output bit s_o,
                                output bit e_o);
    int acc;
    int pv, kv;
    logic [DW-1:0] pb, kb;
    acc = 0; res_o = 0; s_o = 0;
    e_o = (n < 1) || (n > MN);
    if (!e_o) begin
      for (int rr = 0; rr < n; rr++) begin
        for (int cc = 0; cc < n; cc++) begin
          pb = a[(rr*MN+cc)*DW +: DW];
          kb = b[(rr*MN+cc)*DW +: DW];
          pv = ps ? int'($signed(pb)) : int'(pb);
          kv = int'($signed(kb));
          acc += pv * kv;
        end
      end
      if (acc > 32767)       begin res_o = 32767;  s_o = 1; end
      else if (acc < -32768) begin res_o = -32768; s_o = 1; end
      else                         res_o = acc;
    end
  endfunction

  // Drives one start and waits for done; lat counts rising edges after the accepting edge.
  task automatic do_run(input int n, input bit ps, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input bit scramble,
                        output logic [OW-1:0] res, output logic s, output logic e,
                        output int lat, output bit bok, output bit pok);
    @(negedge clk);
    size_n = SZW'(n); pixel_signed = ps; matrix_a = a; matrix_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      matrix_a = rand_mat(); matrix_b = rand_mat();
      size_n = SZW'($urandom_range(0, 7)); pixel_signed = ~ps;
    end
    lat = -1; bok = 1; pok = 1; res = 'x; s = 1'bx; e = 1'bx;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k; res = result; s = sat; e = err;
        if (busy) bok = 0;
        break;
      end
      if (!busy) bok = 0;
      @(posedge clk);
    end
    @(negedge clk);
    if (done) pok = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, result, sat, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h sat=%b err=%b, want all 0",
               busy, done, result, sat, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    int          t_n[5]  = '{2, 2, 2, 3, 5};
    bit          t_ps[5] = '{0, 1, 0, 0, 0};
    logic [7:0]  t_a[5]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0]  t_k[5]  = '{8'h01, 8'h02, 8'h02, 8'h7F, 8'h80};
    logic [15:0] t_r[5]  = '{16'd1020, 16'hFFF8, 16'd2040, 16'h7FFF, 16'h8000};
    bit          t_s[5]  = '{0, 0, 0, 1, 1};
    logic [OW-1:0] res; logic s, e; int lat; bit bok, pok;
    logic [AW-1:0] a, b;
    for (int i = 0; i < 5; i++) begin
      a = {(MN*MN){t_a[i]}};
      b = {(MN*MN){t_k[i]}};
      do_run(t_n[i], t_ps[i], a, b, 1'b0, res, s, e, lat, bok, pok);
      checks++;
      if (res !== t_r[i]) begin
        errors++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, t_r[i]);
      end
      checks++;
      if (s !== t_s[i] || e !== 1'b0) begin
        errors++; $display("FAIL directed_flags[%0d]: got sat=%b err=%b want sat=%b err=0", i, s, e, t_s[i]);
      end
      checks++;
      if (lat !== t_n[i]*t_n[i] || !bok || !pok) begin
        errors++;
        $display("FAIL directed_timing[%0d]: got lat=%0d busy_ok=%0b pulse_ok=%0b want lat=%0d 1 1",
                 i, lat, bok, pok, t_n[i]*t_n[i]);
      end
    end
  endtask

  task automatic test_window();
    logic [OW-1:0] res; logic s, e; int lat; bit bok, pok;
    logic [AW-1:0] a, b;
    a = {(MN*MN){8'hAA}};
    b = {(MN*MN){8'hAA}};
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) b[(r*MN+c)*DW +: DW] = 8'h00;
    a[(1*MN+1)*DW +: DW] = 8'd42;
    b[(1*MN+1)*DW +: DW] = 8'd1;
    for (int sc = 0; sc < 2; sc++) begin
      do_run(3, 1'b0, a, b, sc[0], res, s, e, lat, bok, pok);
      checks++;
      if (res !== 16'd42 || s !== 1'b0 || e !== 1'b0) begin
        errors++;
        $display("FAIL window_identity[scramble=%0d]: got result=%0d sat=%b err=%b want 42 0 0", sc, res, s, e);
      end
    end
    a = rand_mat(); b = rand_mat();
    a[DW-1:0] = 8'd5; b[DW-1:0] = 8'd3;
    do_run(1, 1'b0, a, b, 1'b1, res, s, e, lat, bok, pok);
    checks++;
    if (res !== 16'd15 || lat !== 1) begin
      errors++; $display("FAIL window_n1: got result=%0d lat=%0d want 15 1", res, lat);
    end
  endtask

  task automatic test_invalid_size();
    int sizes[3] = '{0, 6, 7};
    logic [OW-1:0] res; logic s, e; int lat; bit bok, pok;
    for (int i = 0; i < 3; i++) begin
      do_run(sizes[i], 1'b0, rand_mat(), rand_mat(), 1'b0, res, s, e, lat, bok, pok);
      checks++;
      if (res !== '0 || s !== 1'b0 || e !== 1'b1 || lat !== 0 || !bok || !pok) begin
        errors++;
        $display("FAIL invalid_size[%0d]: got result=%h sat=%b err=%b lat=%0d busy_ok=%0b pulse_ok=%0b want 0 0 1 0 1 1",
                 sizes[i], res, s, e, lat, bok, pok);
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [AW-1:0] a, b; int mr; bit ms, me; int ndone; logic [OW-1:0] got;
    a = rand_mat(); b = rand_mat();
    model(3, 1'b1, a, b, mr, ms, me);
    @(negedge clk);
    size_n = 3'd3; pixel_signed = 1'b1; matrix_a = a; matrix_b = b; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; size_n = 3'd1; matrix_a = rand_mat();
    @(negedge clk);
    start = 1'b0;
    ndone = 0; got = 'x;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) begin ndone++; got = result; end
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL start_during_run_pulses: got %0d done pulses want 1", ndone);
    end
    checks++;
    if (got !== OW'(mr)) begin
      errors++; $display("FAIL start_during_run_result: got %h want %h", got, OW'(mr));
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a, b; int mr; bit ms, me; int first, second, ndone;
    a = rand_mat(); b = rand_mat();
    model(2, 1'b0, a, b, mr, ms, me);
    @(negedge clk);
    size_n = 3'd2; pixel_signed = 1'b0; matrix_a = a; matrix_b = b; start = 1'b1;
    first = -1; second = -1; ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) first = c; else if (second < 0) second = c;
        checks++;
        if (result !== OW'(mr)) begin
          errors++; $display("FAIL back_to_back_result: got %h want %h", result, OW'(mr));
        end
      end
    end
    start = 1'b0;
    checks++;
    if (first < 0 || second < 0 || second - first !== 6) begin
      errors++; $display("FAIL back_to_back_period: got first=%0d second=%0d want spacing 6", first, second);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [OW-1:0] res; logic s, e; int lat; bit bok, pok; int ndone;
    logic [AW-1:0] a, b;
    @(negedge clk);
    size_n = 3'd5; pixel_signed = 1'b0; matrix_a = {(MN*MN){8'hFF}}; matrix_b = {(MN*MN){8'h01}};
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, sat, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b result=%h sat=%b err=%b want all 0",
               busy, done, result, sat, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL reset_mid_run_no_done: got %0d done pulses want 0", ndone);
    end
    a = rand_mat(); b = rand_mat();
    a[DW-1:0] = 8'd3; b[DW-1:0] = 8'hFC;
    do_run(1, 1'b0, a, b, 1'b0, res, s, e, lat, bok, pok);
    checks++;
    if (res !== 16'hFFF4 || lat !== 1 || e !== 1'b0) begin
      errors++; $display("FAIL reset_then_n1: got result=%h lat=%0d err=%b want fff4 1 0", res, lat, e);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] res; logic s, e; int lat; bit bok, pok;
    logic [AW-1:0] a, b; int n; bit ps, sc; int mr; bit ms, me; int elat;
    for (int it = 0; it < 40; it++) begin
      n  = ($urandom_range(0, 7) == 0) ? ($urandom_range(0, 1) ? 0 : int'($urandom_range(6, 7)))
                                       : int'($urandom_range(1, MN));
      ps = 1'($urandom_range(0, 1));
      sc = 1'($urandom_range(0, 1));
      a = rand_mat(); b = rand_mat();
      model(n, ps, a, b, mr, ms, me);
      elat = me ? 0 : n*n;
      do_run(n, ps, a, b, sc, res, s, e, lat, bok, pok);
      checks++;
      if (res !== OW'(mr) || s !== ms || e !== me) begin
        errors++;
        $display("FAIL random[%0d] n=%0d ps=%0b: got result=%h sat=%b err=%b want %h %b %b",
                 it, n, ps, res, s, e, OW'(mr), ms, me);
      end
      checks++;
      if (lat !== elat || !bok || !pok) begin
        errors++;
        $display("FAIL random_timing[%0d] n=%0d: got lat=%0d busy_ok=%0b pulse_ok=%0b want %0d 1 1",
                 it, n, lat, bok, pok, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_window();
    test_invalid_size();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
